// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between a client and mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DWIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-request front-end for a single-port tristate-data memory.
// One access per request: IDLE -> WRITE/READ -> RESP -> IDLE.
module mem_access_ctrl #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q;
  logic              we_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              drive_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = bus.req_we ? StWrite : StRead;
      StWrite: state_d = StResp;
      StRead:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture and read-data capture at the close of the access cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == StIdle && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == StWrite) rdata_q <= '0;
      if (state_q == StRead)  rdata_q <= mem_data;
    end
  end

  // Output decode from registered state only; ready is masked while in reset
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_we    = 1'b0;
    bus.rsp_rdata = '0;
    mem_wr        = 1'b0;
    mem_rd        = 1'b0;
    drive_en      = 1'b0;
    unique case (state_q)
      StIdle:  bus.req_ready = rst_n;
      StWrite: begin
        mem_wr   = 1'b1;
        drive_en = 1'b1;
      end
      StRead:  mem_rd = 1'b1;
      StResp:  begin
        bus.rsp_valid = 1'b1;
        bus.rsp_we    = we_q;
        bus.rsp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  assign mem_addr = addr_q;
  // Bus is driven only in WRITE; RESP is the turnaround cycle
  assign mem_data = drive_en ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural tristate memory.
module tb_mem_access_ctrl;

  logic       clk;
  logic       rst_n;
  logic       mem_wr;
  logic       mem_rd;
  logic [4:0] mem_addr;
  wire  [7:0] mem_data;
  logic       mem_load;
  logic [7:0] mem [32];
  int         checks;
  int         errors;

  mem_access_ctrl_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

  mem_access_ctrl #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_wr   (mem_wr),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  // Memory model: sync write, combinational read while rd high
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h40 + 8'(i);
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_data;
    end
  end
  assign mem_data = mem_rd ? mem[mem_addr] : 'z;

  // Released bus settles to 0 so a stray controller drive is visible
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (mem_data[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus invariants checked every cycle
  always @(negedge clk) begin
    checks++;
    if (mem_wr && mem_rd) begin
      errors++;
      $display("FAIL bus_wr_rd_overlap: got wr=%b rd=%b want not both", mem_wr, mem_rd);
    end
    if (!mem_wr && !mem_rd) begin
      checks++;
      if (mem_data !== 8'h00) begin
        errors++;
        $display("FAIL bus_release: got %h want released (00)", mem_data);
      end
    end
    if (mem_rd) begin
      checks++;
      if (mem_data !== mem[mem_addr]) begin
        errors++;
        $display("FAIL bus_contention: got %h want %h", mem_data, mem[mem_addr]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // One full request with rsp_ready high, starting and ending at an idle negedge
  task automatic run_txn(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL txn_idle_ready: got %b want 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if ({mem_wr, mem_rd} !== {we, ~we}) begin
      errors++;
      $display("FAIL txn_access_strobes: got wr/rd %b want %b", {mem_wr, mem_rd}, {we, ~we});
    end
    checks++;
    if (mem_addr !== addr) begin
      errors++;
      $display("FAIL txn_access_addr: got %h want %h", mem_addr, addr);
    end
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL txn_access_hs: got ready/valid %b want 00", {bus.req_ready, bus.rsp_valid});
    end
    if (we) begin
      checks++;
      if (mem_data !== wdata) begin
        errors++;
        $display("FAIL txn_write_data: got %h want %h", mem_data, wdata);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL txn_rsp_valid: got %b want 1", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_we !== we) begin
      errors++;
      $display("FAIL txn_rsp_we: got %b want %b", bus.rsp_we, we);
    end
    checks++;
    if (bus.rsp_rdata !== (we ? 8'h00 : exp_rdata)) begin
      errors++;
      $display("FAIL txn_rsp_rdata: got %h want %h", bus.rsp_rdata, we ? 8'h00 : exp_rdata);
    end
    checks++;
    if ({mem_wr, mem_rd, bus.req_ready} !== 3'b000) begin
      errors++;
      $display("FAIL txn_rsp_quiet: got wr/rd/ready %b want 000",
               {mem_wr, mem_rd, bus.req_ready});
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL txn_back_idle: got valid/ready %b want 01", {bus.rsp_valid, bus.req_ready});
    end
    checks++;
    if (mem_addr !== addr) begin
      errors++;
      $display("FAIL txn_idle_addr: got %h want %h", mem_addr, addr);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_we, mem_wr, mem_rd} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/valid/we/wr/rd %b want 00000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_we, mem_wr, mem_rd});
    end
    checks++;
    if ({mem_addr, bus.rsp_rdata} !== 13'h0) begin
      errors++;
      $display("FAIL reset_data: got addr %h rdata %h want 00 00", mem_addr, bus.rsp_rdata);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_txn(1'b1, 5'd3, 8'hA5, 8'h00);
    run_txn(1'b0, 5'd3, 8'h3C, 8'hA5);
  endtask

  task automatic test_boundaries();
    run_txn(1'b1, 5'd0, 8'hFF, 8'h00);
    run_txn(1'b1, 5'd31, 8'h00, 8'h00);
    run_txn(1'b0, 5'd0, 8'h3C, 8'hFF);
    run_txn(1'b0, 5'd31, 8'h3C, 8'h00);
    run_txn(1'b0, 5'd1, 8'h3C, 8'h41);
  endtask

  task automatic test_backpressure();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'd3;
    bus.req_wdata = 8'h3C;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    // A second request waits behind the stalled response
    bus.req_we    = 1'b1;
    bus.req_addr  = 5'd7;
    bus.req_wdata = 8'h77;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_we, bus.req_ready} !== 3'b100) begin
        errors++;
        $display("FAIL bp_hold_hs[%0d]: got valid/we/ready %b want 100", i,
                 {bus.rsp_valid, bus.rsp_we, bus.req_ready});
      end
      checks++;
      if (bus.rsp_rdata !== 8'hA5) begin
        errors++;
        $display("FAIL bp_hold_rdata[%0d]: got %h want a5", i, bus.rsp_rdata);
      end
      checks++;
      if ({mem_wr, mem_rd} !== 2'b00) begin
        errors++;
        $display("FAIL bp_no_access[%0d]: got wr/rd %b want 00", i, {mem_wr, mem_rd});
      end
      if (i == 4) bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got valid/ready %b want 01", {bus.rsp_valid, bus.req_ready});
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if ({mem_wr, mem_addr, mem_data} !== {1'b1, 5'd7, 8'h77}) begin
      errors++;
      $display("FAIL bp_queued_write: got wr %b addr %h data %h want 1 07 77",
               mem_wr, mem_addr, mem_data);
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_we} !== 2'b11) begin
      errors++;
      $display("FAIL bp_queued_rsp: got valid/we %b want 11", {bus.rsp_valid, bus.rsp_we});
    end
    @(negedge clk);
    run_txn(1'b0, 5'd7, 8'h3C, 8'h77);
  endtask

  task automatic test_back_to_back();
    logic [4:0] ba [4];
    logic       bw [4];
    logic [7:0] bd [4];
    logic [7:0] be [4];
    ba = '{5'd10, 5'd10, 5'd11, 5'd11};
    bw = '{1'b1, 1'b0, 1'b1, 1'b0};
    bd = '{8'h11, 8'h3C, 8'h22, 8'h3C};
    be = '{8'h00, 8'h11, 8'h00, 8'h22};
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_we    = bw[i];
      bus.req_addr  = ba[i];
      bus.req_wdata = bd[i];
      checks++;
      if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
        errors++;
        $display("FAIL b2b_idle[%0d]: got ready/valid %b want 10", i,
                 {bus.req_ready, bus.rsp_valid});
      end
      @(negedge clk);
      checks++;
      if ({mem_wr, mem_rd, mem_addr} !== {bw[i], ~bw[i], ba[i]}) begin
        errors++;
        $display("FAIL b2b_access[%0d]: got wr/rd %b addr %h want %b %h", i,
                 {mem_wr, mem_rd}, mem_addr, {bw[i], ~bw[i]}, ba[i]);
      end
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_we, bus.rsp_rdata} !== {1'b1, bw[i], be[i]}) begin
        errors++;
        $display("FAIL b2b_rsp[%0d]: got valid %b we %b rdata %h want 1 %b %h", i,
                 bus.rsp_valid, bus.rsp_we, bus.rsp_rdata, bw[i], be[i]);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({mem_wr, mem_rd, bus.rsp_valid} !== 3'b000) begin
        errors++;
        $display("FAIL b2b_no_extra: got wr/rd/valid %b want 000",
                 {mem_wr, mem_rd, bus.rsp_valid});
      end
    end
  endtask

  task automatic test_reset_mid();
    // Reset inside the WRITE cycle
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 5'd20;
    bus.req_wdata = 8'h99;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_wr, mem_rd, mem_addr, mem_data} !== 15'h0) begin
      errors++;
      $display("FAIL rst_write_bus: got wr %b rd %b addr %h data %h want 0 0 00 00",
               mem_wr, mem_rd, mem_addr, mem_data);
    end
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_write_hs: got ready/valid %b want 00", {bus.req_ready, bus.rsp_valid});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL rst_write_after: got valid/ready %b want 01",
                 {bus.rsp_valid, bus.req_ready});
      end
    end
    run_txn(1'b1, 5'd20, 8'h5A, 8'h00);
    run_txn(1'b0, 5'd20, 8'h3C, 8'h5A);

    // Reset while a read response is stalled
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'd7;
    bus.req_wdata = 8'h3C;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 8'h77}) begin
      errors++;
      $display("FAIL rst_rsp_pre: got valid %b rdata %h want 1 77",
               bus.rsp_valid, bus.rsp_rdata);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_we, bus.rsp_rdata, mem_addr} !== 15'h0) begin
      errors++;
      $display("FAIL rst_rsp_clear: got valid %b we %b rdata %h addr %h want 0 0 00 00",
               bus.rsp_valid, bus.rsp_we, bus.rsp_rdata, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL rst_rsp_after: got valid/ready %b want 01",
                 {bus.rsp_valid, bus.req_ready});
      end
    end
    run_txn(1'b0, 5'd7, 8'h3C, 8'h77);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    mem_load      = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
